correlator_dump: RTL and testbench

Six-arm integrate-and-dump correlator for the GPS tracking channel. Each arm multiplies a carrier-wiped I or Q sample by the early, prompt or late local code chip. The product accumulates over a programmable number of code periods. At each dump boundary the six 20-bit results are latched and a handshake pulse is raised. Sits directly upstream of the Wishbone register interface: its outputs drive `prompt_idata` … `early_qdata` and `intg_ready` there.

---
 rtl/correlator_dump_if.sv | 37 +++
 rtl/correlator_dump.sv | 157 +++++++++++++++
 tb/tb_correlator_dump.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/correlator_dump_if.sv
// Sample-side inputs and dump-side results of the six-arm correlator.
interface correlator_dump_if #(
  parameter int unsigned IN_W  = 3,
  parameter int unsigned ACC_W = 20
);
  logic             enable;
  logic [4:0]       dump_periods;
  logic             sample_valid;
  logic [IN_W-1:0]  base_i;
  logic [IN_W-1:0]  base_q;
  logic             early_code;
  logic             prompt_code;
  logic             late_code;
  logic             code_epoch;
  logic [ACC_W-1:0] prompt_idata;
  logic [ACC_W-1:0] prompt_qdata;
  logic [ACC_W-1:0] late_idata;
  logic [ACC_W-1:0] late_qdata;
  logic [ACC_W-1:0] early_idata;
  logic [ACC_W-1:0] early_qdata;
  logic             intg_ready;
  logic             acc_overflow;

  modport master (
    output enable, dump_periods, sample_valid, base_i, base_q,
           early_code, prompt_code, late_code, code_epoch,
    input  prompt_idata, prompt_qdata, late_idata, late_qdata,
           early_idata, early_qdata, intg_ready, acc_overflow
  );

  modport slave (
    input  enable, dump_periods, sample_valid, base_i, base_q,
           early_code, prompt_code, late_code, code_epoch,
    output prompt_idata, prompt_qdata, late_idata, late_qdata,
           early_idata, early_qdata, intg_ready, acc_overflow
  );
endinterface

// File: rtl/correlator_dump.sv
// Six-arm (E/P/L x I/Q) saturating integrate-and-dump correlator with dump handshake pulse.
module correlator_dump #(
  parameter int unsigned ACC_W     = 20,
  parameter int unsigned IN_W      = 3,
  parameter int unsigned PULSE_LEN = 4
) (
  input logic              wb_clk_i,
  input logic              wb_rst_i,
  correlator_dump_if.slave bus
);
  localparam int unsigned NARM = 6;
  localparam int unsigned SW   = ACC_W + 1;
  localparam int unsigned PCW  = $clog2(PULSE_LEN + 1);
  localparam logic signed [SW-1:0] SAT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX;

  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q [NARM];
  logic signed [ACC_W-1:0] acc_d [NARM];
  logic signed [ACC_W-1:0] dout_q [NARM];
  logic signed [ACC_W-1:0] dout_d [NARM];
  logic signed [ACC_W-1:0] load_val [NARM];
  logic signed [ACC_W-1:0] sum_val [NARM];
  logic                    load_ovf, sum_ovf;
  logic                    sticky_q, sticky_d;
  logic                    ovf_q, ovf_d;
  logic                    ready_q, ready_d;
  logic [4:0]              per_q, per_d;
  logic [4:0]              n_q, n_d;
  logic [4:0]              n_cap;
  logic [PCW-1:0]          pulse_q, pulse_d;

  function automatic logic signed [SW-1:0] clamp(input logic signed [SW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX;
    if (v < SAT_MIN) return SAT_MIN;
    return v;
  endfunction

  // Arm order: 0/1 early I/Q, 2/3 prompt I/Q, 4/5 late I/Q.
  always_comb begin : arm_math
    logic signed [IN_W-1:0] smp;
    logic signed [SW-1:0]   ext, prd, sum;
    logic                   chip;
    smp      = '0;
    ext      = '0;
    prd      = '0;
    sum      = '0;
    chip     = 1'b0;
    load_ovf = 1'b0;
    sum_ovf  = 1'b0;
    for (int unsigned a = 0; a < NARM; a++) begin
      smp  = (a % 2 == 0) ? signed'(bus.base_i) : signed'(bus.base_q);
      chip = (a < 2) ? bus.early_code : ((a < 4) ? bus.prompt_code : bus.late_code);
      ext  = SW'(smp);
      prd  = chip ? ext : -ext;
      sum  = SW'(acc_q[a]) + prd;
      load_val[a] = ACC_W'(clamp(prd));
      sum_val[a]  = ACC_W'(clamp(sum));
      load_ovf    = load_ovf | (prd != clamp(prd));
      sum_ovf     = sum_ovf | (sum != clamp(sum));
    end
  end

  assign n_cap = (bus.dump_periods == 5'd0) ? 5'd1 : bus.dump_periods;

  // Next-state: alignment, accumulation, dump and handshake countdown.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    dout_d   = dout_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    per_d    = per_q;
    n_d      = n_q;
    pulse_d  = (pulse_q != '0) ? pulse_q - PCW'(1) : pulse_q;

    unique case (state_q)
      IDLE: begin
        if (bus.enable) state_d = ALIGN;
      end
      ALIGN: begin
        if (bus.sample_valid && bus.code_epoch) begin
          state_d  = RUN;
          acc_d    = load_val;
          sticky_d = load_ovf;
          per_d    = 5'd0;
          n_d      = n_cap;
        end
      end
      RUN: begin
        if (bus.sample_valid) begin
          if (bus.code_epoch && (per_q == n_q - 5'd1)) begin
            dout_d   = acc_q;
            ovf_d    = sticky_q;
            acc_d    = load_val;
            sticky_d = load_ovf;
            per_d    = 5'd0;
            n_d      = n_cap;
            pulse_d  = PCW'(PULSE_LEN);
          end else begin
            acc_d    = sum_val;
            sticky_d = sticky_q | sum_ovf;
            if (bus.code_epoch) per_d = per_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable wins over everything except the latched results.
    if (!bus.enable) begin
      state_d  = IDLE;
      sticky_d = 1'b0;
      per_d    = 5'd0;
      for (int unsigned a = 0; a < NARM; a++) acc_d[a] = '0;
    end

    ready_d = (pulse_d != '0);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q  <= IDLE;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b0;
      per_q    <= 5'd0;
      n_q      <= 5'd1;
      pulse_q  <= '0;
      for (int unsigned a = 0; a < NARM; a++) begin
        acc_q[a]  <= '0;
        dout_q[a] <= '0;
      end
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      per_q    <= per_d;
      n_q      <= n_d;
      pulse_q  <= pulse_d;
      acc_q    <= acc_d;
      dout_q   <= dout_d;
    end
  end

  assign bus.early_idata  = dout_q[0];
  assign bus.early_qdata  = dout_q[1];
  assign bus.prompt_idata = dout_q[2];
  assign bus.prompt_qdata = dout_q[3];
  assign bus.late_idata   = dout_q[4];
  assign bus.late_qdata   = dout_q[5];
  assign bus.intg_ready   = ready_q;
  assign bus.acc_overflow = ovf_q;
endmodule

// File: tb/tb_correlator_dump.sv
// Directed bench for correlator_dump: full-width instance plus a narrow instance for saturation.
module tb_correlator_dump;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  correlator_dump_if #(.IN_W(3), .ACC_W(20)) c ();
  correlator_dump_if #(.IN_W(3), .ACC_W(8))  s ();

  correlator_dump #(.ACC_W(20), .IN_W(3), .PULSE_LEN(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (c)
  );

  correlator_dump #(.ACC_W(8), .IN_W(3), .PULSE_LEN(4)) dut_sat (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic v, input logic e);
    c.sample_valid = v;
    c.code_epoch   = e;
    tick();
  endtask

  task automatic body(input int n);
    repeat (n) smp(1'b1, 1'b0);
  endtask

  task automatic s_smp(input logic v, input logic e);
    s.sample_valid = v;
    s.code_epoch   = e;
    tick();
  endtask

  task automatic s_body(input int n);
    repeat (n) s_smp(1'b1, 1'b0);
  endtask

  task automatic idle_inputs();
    c.enable = 1'b0; c.dump_periods = 5'd1; c.sample_valid = 1'b0; c.code_epoch = 1'b0;
    c.base_i = 3'b000; c.base_q = 3'b000;
    c.early_code = 1'b1; c.prompt_code = 1'b1; c.late_code = 1'b1;
    s.enable = 1'b0; s.dump_periods = 5'd1; s.sample_valid = 1'b0; s.code_epoch = 1'b0;
    s.base_i = 3'b000; s.base_q = 3'b000;
    s.early_code = 1'b1; s.prompt_code = 1'b1; s.late_code = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int hi;
    rst_n = 1'b0;
    do_reset();
    chk("rst_pi",  32'(c.prompt_idata), 32'h0);
    chk("rst_eq",  32'(c.early_qdata),  32'h0);
    chk("rst_rdy", 32'(c.intg_ready),   32'h0);
    chk("rst_ovf", 32'(c.acc_overflow), 32'h0);

    // Basic dump: I=+1, Q=-1, all chips +1
    c.enable = 1'b1; c.dump_periods = 5'd1; c.base_i = 3'b001; c.base_q = 3'b111;
    smp(1'b0, 1'b0);
    smp(1'b1, 1'b1);
    body(500);
    smp(1'b0, 1'b1);
    body(522);
    chk("basic_pre_rdy", 32'(c.intg_ready), 32'h0);
    smp(1'b1, 1'b1);
    chk("basic_pi",  32'(c.prompt_idata), 32'h003FF);
    chk("basic_pq",  32'(c.prompt_qdata), 32'hFFC01);
    chk("basic_ei",  32'(c.early_idata),  32'h003FF);
    chk("basic_eq",  32'(c.early_qdata),  32'hFFC01);
    chk("basic_li",  32'(c.late_idata),   32'h003FF);
    chk("basic_lq",  32'(c.late_qdata),   32'hFFC01);
    chk("basic_rdy", 32'(c.intg_ready),   32'h1);
    chk("basic_ovf", 32'(c.acc_overflow), 32'h0);
    hi = 1;
    for (int k = 0; k < 10; k++) begin
      smp(1'b0, 1'b0);
      if (c.intg_ready) hi++;
    end
    chk("basic_pulse_len", 32'(hi), 32'd4);

    // Code sign: prompt chip -1, I=+2
    do_reset();
    c.enable = 1'b1; c.dump_periods = 5'd1; c.base_i = 3'b010; c.prompt_code = 1'b0;
    smp(1'b0, 1'b0);
    smp(1'b1, 1'b1);
    body(1022);
    smp(1'b1, 1'b1);
    chk("sign_pi", 32'(c.prompt_idata), 32'hFF802);
    chk("sign_ei", 32'(c.early_idata),  32'h007FE);
    chk("sign_li", 32'(c.late_idata),   32'h007FE);

    // Multi-period: 3 periods, then 5 (changed mid-integration), then 0 -> 1
    do_reset();
    c.enable = 1'b1; c.dump_periods = 5'd3; c.base_i = 3'b001;
    smp(1'b0, 1'b0);
    smp(1'b1, 1'b1);
    body(500);
    c.dump_periods = 5'd5;
    body(522);
    smp(1'b1, 1'b1); body(1022);
    smp(1'b1, 1'b1); body(1022);
    chk("multi_nodump_rdy", 32'(c.intg_ready), 32'h0);
    chk("multi_nodump_pi",  32'(c.prompt_idata), 32'h0);
    smp(1'b1, 1'b1);
    chk("multi3_pi",  32'(c.prompt_idata), 32'h00BFD);
    chk("multi3_rdy", 32'(c.intg_ready),   32'h1);
    body(1022);
    repeat (4) begin
      smp(1'b1, 1'b1);
      body(1022);
    end
    chk("multi_mid_rdy", 32'(c.intg_ready), 32'h0);
    c.dump_periods = 5'd0;
    smp(1'b1, 1'b1);
    chk("multi5_pi", 32'(c.prompt_idata), 32'h013FB);
    body(1022);
    smp(1'b1, 1'b1);
    chk("multi0_pi", 32'(c.prompt_idata), 32'h003FF);

    // Enable drop mid-integration, then re-align
    body(100);
    c.enable = 1'b0;
    smp(1'b1, 1'b0);
    chk("en_hold_pi", 32'(c.prompt_idata), 32'h003FF);
    smp(1'b0, 1'b0);
    c.enable = 1'b1; c.base_i = 3'b010;
    smp(1'b0, 1'b0);
    smp(1'b1, 1'b1);
    chk("reen_first_rdy", 32'(c.intg_ready),   32'h0);
    chk("reen_first_pi",  32'(c.prompt_idata), 32'h003FF);
    body(1022);
    smp(1'b1, 1'b1);
    chk("reen_dump_pi",  32'(c.prompt_idata), 32'h007FE);
    chk("reen_dump_rdy", 32'(c.intg_ready),   32'h1);

    // Async reset inside an active pulse
    smp(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pi",  32'(c.prompt_idata), 32'h0);
    chk("arst_ei",  32'(c.early_idata),  32'h0);
    chk("arst_rdy", 32'(c.intg_ready),   32'h0);
    chk("arst_ovf", 32'(c.acc_overflow), 32'h0);

    // Back-to-back dumps two cycles apart
    do_reset();
    c.enable = 1'b1; c.dump_periods = 5'd1; c.base_i = 3'b001;
    smp(1'b0, 1'b0);
    smp(1'b1, 1'b1);
    body(1022);
    smp(1'b1, 1'b1);
    chk("b2b_first_pi", 32'(c.prompt_idata), 32'h003FF);
    smp(1'b1, 1'b0);
    smp(1'b1, 1'b1);
    chk("b2b_second_pi",  32'(c.prompt_idata), 32'h00002);
    chk("b2b_second_rdy", 32'(c.intg_ready),   32'h1);
    for (int k = 0; k < 4; k++) begin
      smp(1'b0, 1'b0);
      chk($sformatf("b2b_tail_rdy%0d", k), 32'(c.intg_ready), (k < 3) ? 32'h1 : 32'h0);
    end
    chk("b2b_hold_pi", 32'(c.prompt_idata), 32'h00002);

    // Saturation on the 8-bit instance (limit +/-127)
    c.enable = 1'b0;
    s.enable = 1'b1; s.dump_periods = 5'd1; s.base_i = 3'b011;
    s_smp(1'b0, 1'b0);
    s_smp(1'b1, 1'b1);
    s_body(49);
    s.base_i = 3'b100;
    s_smp(1'b1, 1'b1);
    chk("sat_pos_pi",  32'(s.prompt_idata), 32'h7F);
    chk("sat_pos_ovf", 32'(s.acc_overflow), 32'h1);
    s_body(39);
    s.base_i = 3'b001;
    s_smp(1'b1, 1'b1);
    chk("sat_neg_pi",  32'(s.prompt_idata), 32'h81);
    chk("sat_neg_ovf", 32'(s.acc_overflow), 32'h1);
    s_body(9);
    s_smp(1'b1, 1'b1);
    chk("sat_clr_pi",  32'(s.prompt_idata), 32'h0A);
    chk("sat_clr_ovf", 32'(s.acc_overflow), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
